// File: rtl/rr_addr_arbiter_pkg.sv
// Shared types and constants for the round-robin address arbiter.
// Holds the FSM state encoding and the requester/address sizing.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_addr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// master: drives req/done; slave (arbiter): drives address/enable/timeout.
interface rr_addr_arbiter_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [ADDR_W-1:0]  address;
  logic               enable;
  logic               timeout;

  modport master (
    output req, done,
    input  address, enable, timeout
  );

  modport slave (
    input  req, done,
    output address, enable, timeout
  );

endinterface

// File: rtl/rr_addr_arbiter_pick.sv
// Combinational rotating priority pick: first set req bit from ptr upward.
// Ports: req, ptr in; valid (any req), idx (chosen requester) out.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  int j;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/rr_addr_arbiter.sv
// Round-robin arbiter feeding a registered address/enable to a decoder.
// Ports: clk, rst_n (sync, active-low), bus (slave: req/done in; address/enable/timeout out).
module rr_addr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic clk,
  input  logic rst_n,
  rr_addr_arbiter_if.slave bus
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HSAT = '1;
  localparam logic [HW-1:0] HLIM =
    (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic              to_q, to_d;

  logic              pick_v;
  logic [ADDR_W-1:0] pick_i;
  logic              own_req;
  logic              lim;
  logic              rel;

  rr_pick #(
    .N (NUM_REQ),
    .W (ADDR_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_v),
    .idx   (pick_i)
  );

  assign own_req = bus.req[addr_q];
  assign lim = (MAX_HOLD != 0) && (hold_q == HLIM);
  assign rel = bus.done || !own_req || lim;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    en_d    = en_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (pick_v) begin
          state_d = GRANT;
          addr_d  = pick_i;
          en_d    = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (hold_q != HSAT) hold_d = hold_q + 1'b1;
        if (rel) begin
          state_d = RELEASE;
          en_d    = 1'b0;
          ptr_d   = addr_q + 1'b1;
          // a real release on the limit cycle wins over the timeout
          to_d    = lim && !bus.done && own_req;
        end
      end
      RELEASE: begin
        en_d = 1'b0;
        if (pick_v) begin
          state_d = GRANT;
          addr_d  = pick_i;
          en_d    = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      to_q    <= to_d;
    end
  end

  assign bus.address = addr_q;
  assign bus.enable  = en_q;
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_rr_addr_arbiter.sv
// Directed self-checking bench for rr_addr_arbiter (MAX_HOLD = 15).
// Inputs change 1 time unit after each rising edge; outputs checked there.
module tb_rr_addr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_addr_arbiter_if bus ();

  rr_addr_arbiter #(
    .MAX_HOLD (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic en,
                         input logic [1:0] ad,
                         input logic to);
    chk({tag, ".en"}, 8'(bus.enable), 8'(en));
    chk({tag, ".ad"}, 8'(bus.address), 8'(ad));
    chk({tag, ".to"}, 8'(bus.timeout), 8'(to));
  endtask

  initial begin
    logic [1:0] rot [4];
    checks = 0;
    errors = 0;
    rot[0] = 2'd1;
    rot[1] = 2'd2;
    rot[2] = 2'd3;
    rot[3] = 2'd0;

    // T1 reset
    rst_n    = 1'b0;
    bus.req  = 4'hF;
    bus.done = 1'b0;
    tick();
    tick();
    chk_out("t1_rst", 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("t1_first", 1'b1, 2'd0, 1'b0);

    // T2 rotation with one idle cycle between owners
    for (int k = 0; k < 4; k++) begin
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      chk_out($sformatf("t2_gap%0d", k), 1'b0, rot[(k + 3) % 4], 1'b0);
      tick();
      chk_out($sformatf("t2_gnt%0d", k), 1'b1, rot[k], 1'b0);
    end

    // T3 fairness: owner 0 drops, owner 1 granted, then ptr=2
    bus.req = 4'b0010;
    tick();
    chk_out("t3_drop", 1'b0, 2'd0, 1'b0);
    tick();
    chk_out("t3_g1", 1'b1, 2'd1, 1'b0);
    bus.req = 4'b1011;
    tick();
    chk_out("t3_hold", 1'b1, 2'd1, 1'b0);
    bus.req  = 4'b0011;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk_out("t3_rel", 1'b0, 2'd1, 1'b0);
    tick();
    chk_out("t3_skip", 1'b1, 2'd0, 1'b0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    chk_out("t3_next", 1'b1, 2'd1, 1'b0);

    // T4 timeout after 15 enable cycles
    bus.req = 4'b0100;
    tick();
    chk_out("t4_drop", 1'b0, 2'd1, 1'b0);
    tick();
    chk_out("t4_c1", 1'b1, 2'd2, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      tick();
      chk($sformatf("t4_c%0d", i), 8'(bus.enable), 8'd1);
    end
    tick();
    chk_out("t4_to", 1'b0, 2'd2, 1'b1);
    tick();
    chk_out("t4_regnt", 1'b1, 2'd2, 1'b0);

    // T5 done on the 15th cycle: normal release
    for (int i = 2; i <= 15; i++) tick();
    chk("t5_c15", 8'(bus.enable), 8'd1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk_out("t5_coin", 1'b0, 2'd2, 1'b0);
    tick();
    chk_out("t5_regnt", 1'b1, 2'd2, 1'b0);
    tick();
    tick();
    bus.req = 4'b0000;
    tick();
    chk_out("t5_drop", 1'b0, 2'd2, 1'b0);
    tick();
    chk_out("t5_idle", 1'b0, 2'd2, 1'b0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk_out("t5_done_idle", 1'b0, 2'd2, 1'b0);

    // T6 reset mid-grant clears ptr
    bus.req = 4'b1000;
    tick();
    chk_out("t6_g3", 1'b1, 2'd3, 1'b0);
    tick();
    rst_n   = 1'b0;
    bus.req = 4'b1001;
    tick();
    chk_out("t6_rst", 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("t6_ptr0", 1'b1, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
